// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: round-robin arbiter sharing one register-file write port
module rf_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_BITS  = 32,
  parameter int ADDR_BITS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   addr,
  input  logic [NUM_REQ*NUM_BITS-1:0]    data,
  input  logic                           stall,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           we,
  output logic [ADDR_BITS-1:0]           waddr,
  output logic [NUM_BITS-1:0]            wdata,
  output logic                           multi
);
  localparam int PW = $clog2(NUM_REQ);
  logic [ADDR_BITS-1:0]   a_arr [NUM_REQ];
  logic [NUM_BITS-1:0]    d_arr [NUM_REQ];
  logic [PW-1:0]          ptr, off, win, nxt_ptr;
  logic [PW:0]            sum, diff;
  logic [NUM_REQ-1:0]     elig, rot;
  logic [2*NUM_REQ-1:0]   dbl;
  logic                   found;
  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign a_arr[g] = addr[g*ADDR_BITS +: ADDR_BITS];
      assign d_arr[g] = data[g*NUM_BITS +: NUM_BITS];
    end
  endgenerate
  // rotate eligibility so the pointer sits at bit 0, pick the lowest set bit, rotate back
  always_comb begin
    elig = req & ~gnt;
    dbl = {elig, elig} >> ptr;
    rot = dbl[NUM_REQ-1:0];
    found = |elig;
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) off = PW'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    diff = sum - (PW+1)'(NUM_REQ);
    win = (sum >= (PW+1)'(NUM_REQ)) ? diff[PW-1:0] : sum[PW-1:0];
    nxt_ptr = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  end
  // registered grant, write strobe and payload; stall freezes arbitration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt   <= '0;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      multi <= 1'b0;
      ptr   <= '0;
    end else if (stall) begin
      gnt   <= '0;
      we    <= 1'b0;
      multi <= 1'b0;
    end else begin
      gnt   <= found ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win) : '0;
      we    <= found;
      multi <= $countones(elig) > 1;
      if (found) begin
        waddr <= a_arr[win];
        wdata <= d_arr[win];
        ptr   <= nxt_ptr;
      end
    end
  end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: randomized scoreboard bench with a behavioural arbiter model
module tb_rf_wr_arbiter;
  localparam int N = 4, NB = 32, AB = 4;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*AB-1:0] addr;
  logic [N*NB-1:0] data;
  logic [N-1:0] gnt;
  logic we, multi;
  logic [AB-1:0] waddr;
  logic [NB-1:0] wdata;
  logic [AB-1:0] a_v [N];
  logic [NB-1:0] d_v [N];
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [N-1:0]  gnt;
    logic          we;
    logic [AB-1:0] wa;
    logic [NB-1:0] wd;
    logic          multi;
  } exp_t;
  exp_t q[$];

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_pack
      assign addr[g*AB +: AB] = a_v[g];
      assign data[g*NB +: NB] = d_v[g];
    end
  endgenerate

  rf_wr_arbiter #(.NUM_REQ(N), .NUM_BITS(NB), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .data(data), .stall(stall),
    .gnt(gnt), .we(we), .waddr(waddr), .wdata(wdata), .multi(multi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: pointer as an integer, last winner excluded, scan in circular order
  int m_ptr = 0, m_last = -1;
  logic [AB-1:0] m_wa = '0;
  logic [NB-1:0] m_wd = '0;
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    int win, cnt, idx;
    if (!rst_n) begin
      m_ptr = 0; m_last = -1; m_wa = '0; m_wd = '0;
      q.delete();
    end else begin
      e.gnt = '0; e.we = 1'b0; e.multi = 1'b0;
      if (stall) begin
        m_last = -1;
      end else begin
        win = -1; cnt = 0;
        for (int o = 0; o < N; o++) begin
          idx = (m_ptr + o) % N;
          if (req[idx] && idx != m_last) begin
            cnt++;
            if (win < 0) win = idx;
          end
        end
        e.multi = cnt > 1;
        if (win >= 0) begin
          e.gnt[win] = 1'b1;
          e.we = 1'b1;
          m_wa = a_v[win];
          m_wd = d_v[win];
          m_ptr = (win + 1) % N;
        end
        m_last = win;
      end
      e.wa = m_wa;
      e.wd = m_wd;
      q.push_back(e);
    end
  end

  // monitor: outputs must be zero in reset, otherwise match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_gnt", 64'(gnt), 0);
      chk("rst_we", 64'(we), 0);
      chk("rst_waddr", 64'(waddr), 0);
      chk("rst_wdata", 64'(wdata), 0);
      chk("rst_multi", 64'(multi), 0);
    end else if (q.size() != 0) begin
      e = q.pop_front();
      chk("gnt", 64'(gnt), 64'(e.gnt));
      chk("we", 64'(we), 64'(e.we));
      chk("waddr", 64'(waddr), 64'(e.wa));
      chk("wdata", 64'(wdata), 64'(e.wd));
      chk("multi", 64'(multi), 64'(e.multi));
    end
  end

  task automatic step(input logic [N-1:0] r, input logic s);
    req = r;
    stall = s;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      a_v[i] = AB'($urandom);
      d_v[i] = $urandom;
    end
    req = '1;
    repeat (3) @(negedge clk);
    #1;
    chk("hold_rst_we", 64'(we), 0);
    chk("hold_rst_wdata", 64'(wdata), 0);
    req = '0;
    rst_n = 1'b1;
    step('0, 0);
    a_v[1] = 4'h5;
    d_v[1] = 32'hDEADBEEF;
    step(4'b0010, 0);
    step(4'b0000, 0);
    step(4'b0000, 0);
    do_reset();
    for (int i = 0; i < N; i++) a_v[i] = AB'(i);
    repeat (6) step(4'b1111, 0);
    step(4'b0000, 0);
    repeat (6) step(4'b1000, 0);
    step(4'b0000, 0);
    do_reset();
    repeat (3) step(4'b0101, 1);
    repeat (3) step(4'b0101, 0);
    step(4'b0000, 0);
    do_reset();
    step(4'b0100, 0);
    step(4'b0000, 0);
    step(4'b0011, 0);
    step(4'b0010, 0);
    step(4'b0010, 0);
    step(4'b0000, 0);
    do_reset();
    req = 4'b0100;
    @(posedge clk);
    #2;
    chk("midgrant_gnt", 64'(gnt), 64'h4);
    rst_n = 1'b0;
    #1;
    chk("async_gnt", 64'(gnt), 0);
    chk("async_we", 64'(we), 0);
    chk("async_waddr", 64'(waddr), 0);
    chk("async_wdata", 64'(wdata), 0);
    chk("async_multi", 64'(multi), 0);
    @(negedge clk);
    req = '0;
    rst_n = 1'b1;
    step('0, 0);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0) begin
          a_v[i] = AB'($urandom);
          d_v[i] = $urandom;
        end
      req = N'($urandom);
      stall = ($urandom_range(5) == 0);
      if ($urandom_range(199) == 0) do_reset();
      else @(negedge clk);
    end
    step('0, 0);
    step('0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
